// File: rtl/hilo_mdu_if.sv
// Command/handshake bundle between the EX stage and the HI/LO multiply/divide unit.
interface hilo_mdu_if #(
  parameter int DATA_W = 32
);
  logic              start;
  logic [1:0]        op;
  logic [DATA_W-1:0] src_a;
  logic [DATA_W-1:0] src_b;
  logic              cancel;
  logic              busy;
  logic              stall_req;
  logic              done;

  modport master (
    output start, op, src_a, src_b, cancel,
    input  busy, stall_req, done
  );

  modport slave (
    input  start, op, src_a, src_b, cancel,
    output busy, stall_req, done
  );
endinterface

// File: rtl/hilo_mdu.sv
// HI/LO unit: owns HI/LO, runs an iterative MULT/MULTU/DIV/DIVU engine and
// merges forwarded/direct writes onto one combinational read port per register.

// Read mux for one architectural register (HI or LO).
// Priority: pending MDU result > youngest fwd stage > same-cycle direct write > register.
module hilo_mdu_rdmux #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      mdu_vld,
  input  logic [DATA_W-1:0]         mdu_data,
  input  logic [NUM_FWD-1:0]        fwd_we,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_data,
  input  logic                      wr_en,
  input  logic [DATA_W-1:0]         wr_data,
  input  logic [DATA_W-1:0]         reg_q,
  output logic [DATA_W-1:0]         rdata
);
  // Walk from oldest to youngest so the lowest-index stage wins.
  always_comb begin
    rdata = reg_q;
    if (wr_en) rdata = wr_data;
    for (int i = NUM_FWD - 1; i >= 0; i--) begin
      if (fwd_we[i]) rdata = fwd_data[i*DATA_W +: DATA_W];
    end
    if (mdu_vld) rdata = mdu_data;
  end
endmodule

module hilo_mdu #(
  parameter int DATA_W  = 32,
  parameter int NUM_FWD = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  hilo_mdu_if.slave                 mdu,
  input  logic                      hi_we,
  input  logic                      lo_we,
  input  logic [DATA_W-1:0]         hi_wdata,
  input  logic [DATA_W-1:0]         lo_wdata,
  input  logic [NUM_FWD-1:0]        fwd_hi_we,
  input  logic [NUM_FWD-1:0]        fwd_lo_we,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_hi_data,
  input  logic [NUM_FWD*DATA_W-1:0] fwd_lo_data,
  output logic [DATA_W-1:0]         hi_rdata,
  output logic [DATA_W-1:0]         lo_rdata
);
  localparam int CNT_W = $clog2(DATA_W);
  localparam int LN_LO = 0;
  localparam int LN_HI = 1;

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  // Per-operation control fixed at accept.
  typedef struct packed {
    logic is_div;
    logic neg_q;   // negate product (mult) or quotient (div)
    logic neg_r;   // negate remainder
    logic div0;    // divide by zero: bypass the engine result
  } op_ctl_t;

  state_t              state_q, state_d;
  op_ctl_t             ctl_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [2*DATA_W-1:0] acc_q;    // {HI-side partial, LO-side multiplier/quotient}
  logic [DATA_W-1:0]   opb_q;    // multiplicand / divisor magnitude
  logic [DATA_W-1:0]   a_raw_q;  // original dividend for the divide-by-zero result
  logic [DATA_W-1:0]   hi_q, lo_q;

  logic                accept;
  logic                a_neg, b_neg;
  logic [DATA_W-1:0]   a_mag, b_mag;
  logic [DATA_W:0]     mul_sum;
  logic [2*DATA_W-1:0] mul_next;
  logic [DATA_W:0]     div_shift, div_diff;
  logic                div_ok;
  logic [2*DATA_W-1:0] div_next;
  logic [2*DATA_W-1:0] prod;
  logic [DATA_W-1:0]   res_hi, res_lo;
  logic                mdu_wr;

  assign accept = (state_q == S_IDLE) && mdu.start && !mdu.cancel;
  assign mdu_wr = (state_q == S_DONE) && !mdu.cancel;

  // Operand sign handling: signed ops work on magnitudes, sign reapplied at the end.
  always_comb begin
    a_neg = ~mdu.op[0] & mdu.src_a[DATA_W-1];
    b_neg = ~mdu.op[0] & mdu.src_b[DATA_W-1];
    a_mag = a_neg ? -mdu.src_a : mdu.src_a;
    b_mag = b_neg ? -mdu.src_b : mdu.src_b;
  end

  // One radix-2 step of shift-add multiply and restoring divide.
  always_comb begin
    mul_sum   = {1'b0, acc_q[2*DATA_W-1:DATA_W]} + (acc_q[0] ? {1'b0, opb_q} : '0);
    mul_next  = {mul_sum, acc_q[DATA_W-1:1]};
    div_shift = acc_q[2*DATA_W-1:DATA_W-1];
    div_diff  = div_shift - {1'b0, opb_q};
    div_ok    = ~div_diff[DATA_W];
    div_next  = {(div_ok ? div_diff[DATA_W-1:0] : div_shift[DATA_W-1:0]),
                 acc_q[DATA_W-2:0], div_ok};
  end

  // Final result formatting from the engine accumulator.
  always_comb begin
    prod   = ctl_q.neg_q ? -acc_q : acc_q;
    res_hi = prod[2*DATA_W-1:DATA_W];
    res_lo = prod[DATA_W-1:0];
    if (ctl_q.div0) begin
      res_hi = a_raw_q;
      res_lo = '1;
    end else if (ctl_q.is_div) begin
      res_lo = ctl_q.neg_q ? -acc_q[DATA_W-1:0] : acc_q[DATA_W-1:0];
      res_hi = ctl_q.neg_r ? -acc_q[2*DATA_W-1:DATA_W] : acc_q[2*DATA_W-1:DATA_W];
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state and handshake outputs; cancel overrides everything.
  always_comb begin
    state_d        = state_q;
    mdu.busy      = 1'b0;
    mdu.done      = 1'b0;
    mdu.stall_req = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (accept) state_d = S_RUN;
        mdu.stall_req = mdu.start;
      end
      S_RUN: begin
        mdu.busy      = 1'b1;
        mdu.stall_req = 1'b1;
        if (cnt_q == '0) state_d = S_DONE;
      end
      S_DONE: begin
        mdu.done = 1'b1;
        state_d  = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (mdu.cancel) state_d = S_IDLE;
  end

  // Engine datapath: load at accept, iterate once per RUN cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q   <= '0;
      opb_q   <= '0;
      a_raw_q <= '0;
      ctl_q   <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      acc_q        <= {{DATA_W{1'b0}}, a_mag};
      opb_q        <= b_mag;
      a_raw_q      <= mdu.src_a;
      ctl_q.is_div <= mdu.op[1];
      ctl_q.neg_q  <= a_neg ^ b_neg;
      ctl_q.neg_r  <= a_neg;
      ctl_q.div0   <= mdu.op[1] && (mdu.src_b == '0);
      cnt_q        <= CNT_W'(DATA_W - 1);
    end else if (state_q == S_RUN) begin
      acc_q <= ctl_q.is_div ? div_next : mul_next;
      cnt_q <= cnt_q - 1'b1;
    end
  end

  // Architectural HI/LO: MDU result beats direct writes (it is the younger op).
  always_ff @(posedge clk) begin
    if (rst) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (mdu_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (hi_we) hi_q <= hi_wdata;
      if (lo_we) lo_q <= lo_wdata;
    end
  end

  // Per-register read lanes (lane 0 = LO, lane 1 = HI).
  logic [1:0][DATA_W-1:0]         ln_res, ln_wdata, ln_reg, ln_rdata;
  logic [1:0]                     ln_we;
  logic [1:0][NUM_FWD-1:0]        ln_fwd_we;
  logic [1:0][NUM_FWD*DATA_W-1:0] ln_fwd_data;

  always_comb begin
    ln_res[LN_LO]      = res_lo;
    ln_res[LN_HI]      = res_hi;
    ln_wdata[LN_LO]    = lo_wdata;
    ln_wdata[LN_HI]    = hi_wdata;
    ln_reg[LN_LO]      = lo_q;
    ln_reg[LN_HI]      = hi_q;
    ln_we[LN_LO]       = lo_we;
    ln_we[LN_HI]       = hi_we;
    ln_fwd_we[LN_LO]   = fwd_lo_we;
    ln_fwd_we[LN_HI]   = fwd_hi_we;
    ln_fwd_data[LN_LO] = fwd_lo_data;
    ln_fwd_data[LN_HI] = fwd_hi_data;
  end

  for (genvar g = 0; g < 2; g++) begin : g_rd
    hilo_mdu_rdmux #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) u_rdmux (
      .mdu_vld  (state_q == S_DONE),
      .mdu_data (ln_res[g]),
      .fwd_we   (ln_fwd_we[g]),
      .fwd_data (ln_fwd_data[g]),
      .wr_en    (ln_we[g]),
      .wr_data  (ln_wdata[g]),
      .reg_q    (ln_reg[g]),
      .rdata    (ln_rdata[g])
    );
  end

  assign lo_rdata = ln_rdata[LN_LO];
  assign hi_rdata = ln_rdata[LN_HI];
endmodule

// File: tb/tb_hilo_mdu.sv
// Bench for hilo_mdu: vector table + random ops through a scoreboard queue,
// plus directed cancel / collision / forwarding / reset sequences.
module tb_hilo_mdu;
  localparam int DATA_W  = 32;
  localparam int NUM_FWD = 2;

  logic                      clk, rst;
  logic                      hi_we, lo_we;
  logic [DATA_W-1:0]         hi_wdata, lo_wdata;
  logic [NUM_FWD-1:0]        fwd_hi_we, fwd_lo_we;
  logic [NUM_FWD*DATA_W-1:0] fwd_hi_data, fwd_lo_data;
  logic [DATA_W-1:0]         hi_rdata, lo_rdata;

  hilo_mdu_if #(.DATA_W(DATA_W)) mif ();

  hilo_mdu #(.DATA_W(DATA_W), .NUM_FWD(NUM_FWD)) dut (
    .clk         (clk),
    .rst         (rst),
    .mdu         (mif),
    .hi_we       (hi_we),
    .lo_we       (lo_we),
    .hi_wdata    (hi_wdata),
    .lo_wdata    (lo_wdata),
    .fwd_hi_we   (fwd_hi_we),
    .fwd_lo_we   (fwd_lo_we),
    .fwd_hi_data (fwd_hi_data),
    .fwd_lo_data (fwd_lo_data),
    .hi_rdata    (hi_rdata),
    .lo_rdata    (lo_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a, b, hi, lo;
  } vec_t;

  int          n_vec = 0;
  int          n_mis = 0;
  logic [63:0] sb_q[$];
  logic [63:0] last_res;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {HI, LO} from plain integer arithmetic.
  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      2'b00: p = 64'(sa * sb);
      2'b01: p = {32'b0, a} * {32'b0, b};
      default: begin
        if (b == 32'd0) p = {a, 32'hFFFF_FFFF};
        else if (o == 2'b10) begin
          q = sa / sb;
          r = sa % sb;
          p = {r[31:0], q[31:0]};
        end else p = {a % b, a / b};
      end
    endcase
    return p;
  endfunction

  // Called at a negedge; returns at the negedge right after the accept edge.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input bit push, input logic [63:0] e);
    mif.start = 1'b1; mif.op = o; mif.src_a = a; mif.src_b = b;
    #1 chk("stall_req_on_start", 64'(mif.stall_req), 64'd1);
    if (push) sb_q.push_back(e);
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
  endtask

  // Waits for done (bounded), checks latency, busy length, DONE-cycle view and final HI/LO.
  task automatic wait_done(input int cyc0, input bit collide, input bit btb, input logic [63:0] btb_exp);
    int cyc, nb;
    logic [63:0] e;
    cyc = cyc0;
    nb  = cyc0;
    while (1) begin
      if (mif.busy) nb++;
      if (mif.done) break;
      if (cyc >= 200) break;
      @(negedge clk);
      cyc++;
    end
    chk("done_latency", 64'(cyc), 64'(DATA_W));
    chk("busy_cycles", 64'(nb), 64'(DATA_W));
    if (sb_q.size() == 0) begin
      n_vec++; n_mis++;
      $display("FAIL scoreboard_empty: got 0 entries expected 1");
      e = '0;
    end else e = sb_q.pop_front();
    if (collide) begin lo_we = 1'b1; lo_wdata = 32'h9; end
    if (btb) begin
      mif.start = 1'b1; mif.op = 2'b01; mif.src_a = 32'd2; mif.src_b = 32'd2;
      sb_q.push_back(btb_exp);
    end
    #1;
    chk("done_view_hi", 64'(hi_rdata), 64'(e[63:32]));
    chk("done_view_lo", 64'(lo_rdata), 64'(e[31:0]));
    @(negedge clk);
    lo_we = 1'b0;
    #1;
    chk("reg_hi", 64'(hi_rdata), 64'(e[63:32]));
    chk("reg_lo", 64'(lo_rdata), 64'(e[31:0]));
    if (btb) chk("start_in_done_ignored", 64'(mif.busy), 64'd0);
    last_res = e;
  endtask

  vec_t vt[13];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vt[0]  = '{2'b00, 32'hFFFF_FFFD, 32'd5,          32'hFFFF_FFFF, 32'hFFFF_FFF1};
    vt[1]  = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF,  32'hFFFF_FFFE, 32'h0000_0001};
    vt[2]  = '{2'b11, 32'd100,       32'd7,          32'd2,         32'd14};
    vt[3]  = '{2'b10, 32'hFFFF_FFF9, 32'd2,          32'hFFFF_FFFF, 32'hFFFF_FFFD};
    vt[4]  = '{2'b10, 32'd5,         32'd0,          32'd5,         32'hFFFF_FFFF};
    vt[5]  = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF,  32'd0,         32'h8000_0000};
    vt[6]  = '{2'b11, 32'hFFFF_FFF9, 32'd0,          32'hFFFF_FFF9, 32'hFFFF_FFFF};
    vt[7]  = '{2'b00, 32'd7,         32'hFFFF_FFFA,  32'hFFFF_FFFF, 32'hFFFF_FFD6};
    vt[8]  = '{2'b00, 32'hFFFF_FFFC, 32'hFFFF_FFF8,  32'd0,         32'd32};
    vt[9]  = '{2'b00, 32'h8000_0000, 32'h8000_0000,  32'h4000_0000, 32'd0};
    vt[10] = '{2'b01, 32'h1234_5678, 32'h100,        32'h12,        32'h3456_7800};
    vt[11] = '{2'b10, 32'd7,         32'hFFFF_FFFE,  32'd1,         32'hFFFF_FFFD};
    vt[12] = '{2'b11, 32'hFFFF_FFFF, 32'd1,          32'd0,         32'hFFFF_FFFF};

    rst = 1'b1; hi_we = 0; lo_we = 0; hi_wdata = '0; lo_wdata = '0;
    fwd_hi_we = '0; fwd_lo_we = '0; fwd_hi_data = '0; fwd_lo_data = '0;
    mif.start = 0; mif.op = '0; mif.src_a = '0; mif.src_b = '0; mif.cancel = 0;
    last_res = '0;
    repeat (2) @(negedge clk);

    // Reset state
    #1;
    chk("rst_busy", 64'(mif.busy), 64'd0);
    chk("rst_done", 64'(mif.done), 64'd0);
    chk("rst_hi", 64'(hi_rdata), 64'd0);
    chk("rst_lo", 64'(lo_rdata), 64'd0);
    chk("rst_stall_idle", 64'(mif.stall_req), 64'd0);
    mif.start = 1'b1;
    #1 chk("rst_stall_follows_start", 64'(mif.stall_req), 64'd1);
    mif.start = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Table vectors
    for (int i = 0; i < 13; i++) begin
      issue(vt[i].op, vt[i].a, vt[i].b, 1'b1, {vt[i].hi, vt[i].lo});
      wait_done(0, 1'b0, 1'b0, '0);
    end

    // Random ops against the arithmetic model
    for (int i = 0; i < 8; i++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = $urandom;
      b = (i == 3) ? 32'd0 : $urandom;
      if (i[0]) b = b >> $urandom_range(0, 28);
      issue(o, a, b, 1'b1, model(o, a, b));
      wait_done(0, 1'b0, 1'b0, '0);
    end

    // Cancel mid-RUN: no write, idle next cycle, new start accepted on the following edge
    issue(2'b01, 32'd3, 32'd3, 1'b0, '0);
    repeat (9) @(negedge clk);
    mif.cancel = 1'b1;
    @(posedge clk);
    @(negedge clk);
    mif.cancel = 1'b0;
    #1;
    chk("cancel_busy", 64'(mif.busy), 64'd0);
    chk("cancel_hi_kept", 64'(hi_rdata), 64'(last_res[63:32]));
    chk("cancel_lo_kept", 64'(lo_rdata), 64'(last_res[31:0]));
    issue(2'b11, 32'd100, 32'd7, 1'b1, {32'd2, 32'd14});
    chk("accept_after_cancel", 64'(mif.busy), 64'd1);
    wait_done(0, 1'b0, 1'b0, '0);

    // cancel beats start in IDLE
    mif.start = 1'b1; mif.cancel = 1'b1; mif.op = 2'b00;
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0; mif.cancel = 1'b0;
    #1 chk("cancel_beats_start", 64'(mif.busy), 64'd0);

    // Start ignored in RUN, DONE result beats lo_we, start in DONE deferred one edge
    issue(2'b01, 32'd5, 32'd1, 1'b1, {32'd0, 32'd5});
    mif.start = 1'b1; mif.op = 2'b01; mif.src_a = 32'd9; mif.src_b = 32'd9;
    repeat (3) @(negedge clk);
    mif.start = 1'b0;
    wait_done(3, 1'b1, 1'b1, {32'd0, 32'd4});
    @(posedge clk);
    @(negedge clk);
    mif.start = 1'b0;
    chk("btb_accepted", 64'(mif.busy), 64'd1);
    wait_done(0, 1'b0, 1'b0, '0);

    // Forwarding priority on HI, and one LO lane check
    hi_we = 1'b1; hi_wdata = 32'h11;
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0;
    #1 chk("hi_reg_11", 64'(hi_rdata), 64'h11);
    fwd_hi_data = {32'hBB, 32'hAA};
    fwd_hi_we = 2'b11;
    #1 chk("fwd_11_youngest", 64'(hi_rdata), 64'hAA);
    fwd_hi_we = 2'b10;
    #1 chk("fwd_10_stage1", 64'(hi_rdata), 64'hBB);
    fwd_hi_we = 2'b01;
    #1 chk("fwd_01_stage0", 64'(hi_rdata), 64'hAA);
    hi_we = 1'b1; hi_wdata = 32'hCC;
    fwd_hi_we = 2'b10;
    #1 chk("fwd_beats_direct", 64'(hi_rdata), 64'hBB);
    fwd_hi_we = 2'b00;
    #1 chk("direct_bypass", 64'(hi_rdata), 64'hCC);
    fwd_lo_data = {32'h22, 32'h33};
    fwd_lo_we = 2'b10;
    #1 chk("fwd_lo_stage1", 64'(lo_rdata), 64'h22);
    @(posedge clk);
    @(negedge clk);
    hi_we = 1'b0; fwd_lo_we = 2'b00;
    #1 chk("hi_reg_cc", 64'(hi_rdata), 64'hCC);

    // Reset mid-RUN
    issue(2'b00, 32'd7, 32'd7, 1'b0, '0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("midrun_rst_busy", 64'(mif.busy), 64'd0);
    chk("midrun_rst_hi", 64'(hi_rdata), 64'd0);
    chk("midrun_rst_lo", 64'(lo_rdata), 64'd0);
    repeat (40) @(negedge clk);
    chk("midrun_rst_no_done", 64'(mif.done), 64'd0);
    chk("midrun_rst_no_write", 64'(lo_rdata), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
